ru_fault_allocator: RTL and testbench

- Sequences redundant-unit (RU) assignment for the BISR systolic array.
- On each STW completion it latches the per-PE fault matrix and scans columns one per cycle.
- It binds each faulty column to the next free RU, then atomically commits `ru_en` and the RU-to-column mapping consumed by the recompute module and the bottom-output mux.
- It sits between the STW-enabled systolic array and the recompute module/controller.

---
 rtl/ru_fault_allocator_pkg.sv | 19 +
 rtl/ru_fault_allocator_if.sv | 34 +++
 rtl/ru_fault_allocator_col_reduce.sv | 24 ++
 rtl/ru_fault_allocator.sv | 129 ++++++++++++
 tb/tb_ru_fault_allocator.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/ru_fault_allocator_pkg.sv
// Shared types and sizing helpers for the redundant-unit fault allocator.
package ru_fault_allocator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } allocState_t;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_NUM_RU = 4;

  // Index width for n entries, never narrower than one bit.
  function automatic int widthOf(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ru_fault_allocator_if.sv
// Fault-matrix input and committed RU mapping bundle of the allocator.
interface ru_fault_allocator_if
  import ru_fault_allocator_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int NUM_RU = DEF_NUM_RU
) ();
  localparam int CB = widthOf(COLS);
  localparam int RB = widthOf(NUM_RU);

  logic                   stw_complete;
  logic [ROWS*COLS-1:0]   fault_mat;
  logic                   clear_map;
  logic [NUM_RU-1:0]      ru_en;
  logic [CB*NUM_RU-1:0]   ru_col_mapping;
  logic [COLS-1:0]        col_remapped;
  logic [RB*COLS-1:0]     col_ru_idx;
  logic                   alloc_busy;
  logic                   alloc_done;
  logic                   unrepairable;

  modport master (
    output stw_complete, fault_mat, clear_map,
    input  ru_en, ru_col_mapping, col_remapped, col_ru_idx,
           alloc_busy, alloc_done, unrepairable
  );

  modport slave (
    input  stw_complete, fault_mat, clear_map,
    output ru_en, ru_col_mapping, col_remapped, col_ru_idx,
           alloc_busy, alloc_done, unrepairable
  );
endinterface

// File: rtl/ru_fault_allocator_col_reduce.sv
// Combinational OR-reduction telling whether any PE of the selected column is faulty.
module ru_col_fault_reduce
  import ru_fault_allocator_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int CB   = widthOf(DEF_COLS)
) (
  input  logic [ROWS*COLS-1:0] i_faultMat,
  input  logic [CB-1:0]        i_colSel,
  output logic                 o_colFaulty
);
  logic [COLS-1:0] w_colAny;

  // Fold every row onto one per-column vector, then pick the scanned column.
  always_comb begin
    w_colAny = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_colAny = w_colAny | i_faultMat[r*COLS +: COLS];
    end
  end

  assign o_colFaulty = w_colAny[i_colSel];
endmodule

// File: rtl/ru_fault_allocator.sv
// Scans the latched fault matrix column by column and atomically commits RU bindings.
// Define RU_ALLOC_STICKY_EN to accumulate faults across STW runs until clear/reset.
module ru_fault_allocator
  import ru_fault_allocator_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int NUM_RU = DEF_NUM_RU
) (
  input  logic                 clk,
  input  logic                 rst,
  ru_fault_allocator_if.slave  bus
);
  localparam int CB = widthOf(COLS);
  localparam int RB = widthOf(NUM_RU);
  localparam int NB = widthOf(NUM_RU + 1);
  localparam logic [CB-1:0] LAST_COL = CB'(COLS - 1);
  localparam logic [NB-1:0] RU_LIMIT = NB'(NUM_RU);

  allocState_t              r_state;
  allocState_t              w_nextState;
  logic [ROWS*COLS-1:0]     r_faultMat;
  logic [CB-1:0]            r_colPtr;
  logic [NB-1:0]            r_nextRu;
  logic                     w_colFaulty;

  logic [NUM_RU-1:0]          r_shEn, r_ruEn;
  logic [NUM_RU-1:0][CB-1:0]  r_shMap, r_ruMap;
  logic [COLS-1:0]            r_shColv, r_colRemap;
  logic [COLS-1:0][RB-1:0]    r_shColIdx, r_colRuIdx;
  logic                       r_shUnrep, r_unrep;

  ru_col_fault_reduce #(
    .ROWS (ROWS),
    .COLS (COLS),
    .CB   (CB)
  ) u_reduce (
    .i_faultMat  (r_faultMat),
    .i_colSel    (r_colPtr),
    .o_colFaulty (w_colFaulty)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (bus.clear_map) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.stw_complete) w_nextState = SCAN;
        SCAN:    if (r_colPtr == LAST_COL) w_nextState = COMMIT;
        COMMIT:  w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Bindings build up in shadow registers so the datapath never sees a half-done map.
  always_ff @(posedge clk) begin
    if (!rst || bus.clear_map) begin
      r_faultMat <= '0;
      r_colPtr   <= '0;
      r_nextRu   <= '0;
      r_shEn     <= '0;
      r_shMap    <= '0;
      r_shColv   <= '0;
      r_shColIdx <= '0;
      r_shUnrep  <= 1'b0;
      r_ruEn     <= '0;
      r_ruMap    <= '0;
      r_colRemap <= '0;
      r_colRuIdx <= '0;
      r_unrep    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.stw_complete) begin
`ifdef RU_ALLOC_STICKY_EN
            r_faultMat <= r_faultMat | bus.fault_mat;
`else
            r_faultMat <= bus.fault_mat;
`endif
            r_colPtr   <= '0;
            r_nextRu   <= '0;
            r_shEn     <= '0;
            r_shMap    <= '0;
            r_shColv   <= '0;
            r_shColIdx <= '0;
            r_shUnrep  <= 1'b0;
          end
        end
        SCAN: begin
          if (w_colFaulty) begin
            if (r_nextRu < RU_LIMIT) begin
              r_shEn[r_nextRu[RB-1:0]]  <= 1'b1;
              r_shMap[r_nextRu[RB-1:0]] <= r_colPtr;
              r_shColv[r_colPtr]        <= 1'b1;
              r_shColIdx[r_colPtr]      <= r_nextRu[RB-1:0];
              r_nextRu                  <= r_nextRu + 1'b1;
            end else begin
              r_shUnrep <= 1'b1;
            end
          end
          r_colPtr <= r_colPtr + 1'b1;
        end
        COMMIT: begin
          r_ruEn     <= r_shEn;
          r_ruMap    <= r_shMap;
          r_colRemap <= r_shColv;
          r_colRuIdx <= r_shColIdx;
          r_unrep    <= r_shUnrep;
        end
        default: ;
      endcase
    end
  end

  assign bus.ru_en          = r_ruEn;
  assign bus.ru_col_mapping = r_ruMap;
  assign bus.col_remapped   = r_colRemap;
  assign bus.col_ru_idx     = r_colRuIdx;
  assign bus.unrepairable   = r_unrep;
  assign bus.alloc_busy     = (r_state == SCAN);
  assign bus.alloc_done     = (r_state == COMMIT) && !bus.clear_map;
endmodule

// File: tb/tb_ru_fault_allocator.sv
// Directed bench for ru_fault_allocator: a 4x4 array with 4 RUs and a 2-RU overflow copy.
module tb_ru_fault_allocator;

  typedef struct {
    logic [15:0] fm;
    logic [3:0]  ruEn;
    logic [7:0]  map;
    logic [3:0]  colRem;
    logic [7:0]  colIdx;
    logic        unrep;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stwComplete;
  logic [15:0] faultMat;
  logic        clearMap;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  ru_fault_allocator_if #(.ROWS(4), .COLS(4), .NUM_RU(4)) bus4 ();
  ru_fault_allocator_if #(.ROWS(4), .COLS(4), .NUM_RU(2)) bus2 ();

  assign bus4.stw_complete = stwComplete;
  assign bus4.fault_mat    = faultMat;
  assign bus4.clear_map    = clearMap;
  assign bus2.stw_complete = stwComplete;
  assign bus2.fault_mat    = faultMat;
  assign bus2.clear_map    = clearMap;

  ru_fault_allocator #(.ROWS(4), .COLS(4), .NUM_RU(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  ru_fault_allocator #(.ROWS(4), .COLS(4), .NUM_RU(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect4(input string name, input logic [3:0] ruEn, input logic [7:0] map,
                         input logic [3:0] colRem, input logic [7:0] colIdx, input logic unrep);
    checkOutput({name, " ru_en"}, 32'(bus4.ru_en), 32'(ruEn));
    checkOutput({name, " ru_col_mapping"}, 32'(bus4.ru_col_mapping), 32'(map));
    checkOutput({name, " col_remapped"}, 32'(bus4.col_remapped), 32'(colRem));
    checkOutput({name, " col_ru_idx"}, 32'(bus4.col_ru_idx), 32'(colIdx));
    checkOutput({name, " unrepairable"}, 32'(bus4.unrepairable), 32'(unrep));
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clearMap = 1'b1;
    @(negedge clk);
    clearMap = 1'b0;
  endtask

  // Launches stw_complete at step 0 and observes eight following cycles; optional
  // extra stw, clear or reset pulses are injected at the given steps (-1 = none).
  task automatic applyStimulus(input logic [15:0] fm, input int extraStwAt, input int clearAt,
                               input int rstAt, output int busyCnt, output int doneCnt,
                               output int doneAt);
    busyCnt = 0;
    doneCnt = 0;
    doneAt  = -1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (bus4.alloc_busy) busyCnt++;
        if (bus4.alloc_done) begin
          doneCnt++;
          if (doneAt < 0) doneAt = k;
        end
      end
      stwComplete = (k == 0) || (k == extraStwAt);
      faultMat    = (k == 0) ? fm : 16'hFFFF;
      clearMap    = (k == clearAt);
      rst         = (k == rstAt) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    int   busyCnt, doneCnt, doneAt;
    vec_t vecs[6];

    vecs[0] = '{fm:16'h0000, ruEn:4'b0000, map:8'h00, colRem:4'b0000, colIdx:8'h00, unrep:1'b0};
    vecs[1] = '{fm:16'h1040, ruEn:4'b0011, map:8'h08, colRem:4'b0101, colIdx:8'h10, unrep:1'b0};
    vecs[2] = '{fm:16'h000F, ruEn:4'b1111, map:8'hE4, colRem:4'b1111, colIdx:8'hE4, unrep:1'b0};
    vecs[3] = '{fm:16'h0800, ruEn:4'b0001, map:8'h03, colRem:4'b1000, colIdx:8'h00, unrep:1'b0};
    vecs[4] = '{fm:16'h2008, ruEn:4'b0011, map:8'h0D, colRem:4'b1010, colIdx:8'h40, unrep:1'b0};
    vecs[5] = '{fm:16'hFFFF, ruEn:4'b1111, map:8'hE4, colRem:4'b1111, colIdx:8'hE4, unrep:1'b0};

    rst         = 1'b0;
    stwComplete = 1'b0;
    faultMat    = '0;
    clearMap    = 1'b0;
    repeat (2) @(negedge clk);
    expect4("reset", 4'b0, 8'h0, 4'b0, 8'h0, 1'b0);
    checkOutput("reset alloc_busy", 32'(bus4.alloc_busy), 32'd0);
    checkOutput("reset alloc_done", 32'(bus4.alloc_done), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      pulseClear();
      applyStimulus(vecs[i].fm, -1, -1, -1, busyCnt, doneCnt, doneAt);
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyCnt), 32'd4);
      checkOutput($sformatf("vec%0d done count", i), 32'(doneCnt), 32'd1);
      checkOutput($sformatf("vec%0d done latency", i), 32'(doneAt), 32'd5);
      expect4($sformatf("vec%0d", i), vecs[i].ruEn, vecs[i].map, vecs[i].colRem,
              vecs[i].colIdx, vecs[i].unrep);
    end

    $display("[TB] overflow with two RUs");
    pulseClear();
    applyStimulus(16'hFFFF, -1, -1, -1, busyCnt, doneCnt, doneAt);
    checkOutput("ovf ru_en", 32'(bus2.ru_en), 32'h3);
    checkOutput("ovf ru_col_mapping", 32'(bus2.ru_col_mapping), 32'h4);
    checkOutput("ovf col_remapped", 32'(bus2.col_remapped), 32'h3);
    checkOutput("ovf col_ru_idx", 32'(bus2.col_ru_idx), 32'h2);
    checkOutput("ovf unrepairable", 32'(bus2.unrepairable), 32'h1);
    checkOutput("ovf four-RU unrepairable", 32'(bus4.unrepairable), 32'h0);

    $display("[TB] stw_complete while busy");
    pulseClear();
    applyStimulus(16'h0040, 2, -1, -1, busyCnt, doneCnt, doneAt);
    checkOutput("stw-in-scan busy cycles", 32'(busyCnt), 32'd4);
    checkOutput("stw-in-scan done count", 32'(doneCnt), 32'd1);
    expect4("stw-in-scan", 4'b0001, 8'h02, 4'b0100, 8'h00, 1'b0);
    applyStimulus(16'h0040, 5, -1, -1, busyCnt, doneCnt, doneAt);
    checkOutput("stw-in-commit busy cycles", 32'(busyCnt), 32'd4);
    checkOutput("stw-in-commit done count", 32'(doneCnt), 32'd1);
    expect4("stw-in-commit", 4'b0001, 8'h02, 4'b0100, 8'h00, 1'b0);

    $display("[TB] clear_map handling");
    applyStimulus(16'hFFFF, -1, 2, -1, busyCnt, doneCnt, doneAt);
    checkOutput("clear-mid-scan busy cycles", 32'(busyCnt), 32'd2);
    checkOutput("clear-mid-scan done count", 32'(doneCnt), 32'd0);
    checkOutput("clear-mid-scan idle", 32'(bus4.alloc_busy), 32'd0);
    expect4("clear-mid-scan", 4'b0, 8'h0, 4'b0, 8'h0, 1'b0);
    applyStimulus(16'h0001, -1, 0, -1, busyCnt, doneCnt, doneAt);
    checkOutput("clear+stw busy cycles", 32'(busyCnt), 32'd0);
    checkOutput("clear+stw done count", 32'(doneCnt), 32'd0);

    $display("[TB] reset mid-scan then restart");
    applyStimulus(16'h000F, -1, -1, -1, busyCnt, doneCnt, doneAt);
    applyStimulus(16'hFFFF, -1, -1, 2, busyCnt, doneCnt, doneAt);
    checkOutput("rst-mid-scan done count", 32'(doneCnt), 32'd0);
    expect4("rst-mid-scan", 4'b0, 8'h0, 4'b0, 8'h0, 1'b0);
    applyStimulus(16'h0800, -1, -1, -1, busyCnt, doneCnt, doneAt);
    checkOutput("restart done latency", 32'(doneAt), 32'd5);
    checkOutput("restart busy cycles", 32'(busyCnt), 32'd4);
    expect4("restart", 4'b0001, 8'h03, 4'b1000, 8'h00, 1'b0);

    $display("[TB] back-to-back runs");
    pulseClear();
    applyStimulus(16'h0002, -1, -1, -1, busyCnt, doneCnt, doneAt);
    expect4("run1", 4'b0001, 8'h01, 4'b0010, 8'h00, 1'b0);
    applyStimulus(16'h8000, -1, -1, -1, busyCnt, doneCnt, doneAt);
`ifdef RU_ALLOC_STICKY_EN
    expect4("run2 sticky", 4'b0011, 8'h0D, 4'b1010, 8'h40, 1'b0);
`else
    expect4("run2", 4'b0001, 8'h03, 4'b1000, 8'h00, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
